// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Covers the FSM state encoding, the opcodes and the instruction field positions.
package instr_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_J    = 3'b101,
    OP_JAL  = 3'b110,
    OP_ADDI = 3'b111
  } opcode_e;

  // Field positions inside the 16-bit instruction word.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int JT_MSB   = 12;
  localparam int JT_LSB   = 0;
  localparam int IMM7_MSB = 6;
  localparam int IMM7_LSB = 0;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: jump target, taken branch or sequential.
// Only the low 13 instruction bits feed any target, so only those come in.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [12:0] instr_lo,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [15:0] pc_plus2,
  output logic [15:0] next_pc
);

  logic [15:0] br_off;
  logic [15:0] br_target;
  logic [15:0] j_target;

  assign pc_plus2  = pc + 16'd2;
  // Word offset sign-extended and scaled to bytes; sums wrap modulo 2^16.
  assign br_off    = {{8{instr_lo[IMM7_MSB]}}, instr_lo[IMM7_MSB:IMM7_LSB], 1'b0};
  assign br_target = pc_plus2 + br_off;
  assign j_target  = {pc_plus2[15:14], instr_lo[JT_MSB:JT_LSB], 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (jump) begin
      next_pc = j_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests a word at pc, holds it for execute,
// then advances pc through pc_next and counts retired instructions.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [15:0] pc_plus2,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [15:0] instr_count
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  count_q, count_d;
  logic [15:0]  next_pc;

  pc_next u_pc_next (
    .pc       (pc_q),
    .instr_lo (instr_q[JT_MSB:0]),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .pc_plus2 (pc_plus2),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_done) begin
          pc_d    = next_pc;
          count_d = count_q + 16'd1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit 0 is forced low so a misaligned PC can never be requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= {RESET_PC[15:1], 1'b0};
      instr_q <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[15:1], 1'b0};
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_ISSUE);
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized fetch sequences checked against an arithmetic PC model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] pc_plus2;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_pc = 0;
  int exp_count = 0;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .pc_plus2    (pc_plus2),
    .exec_done   (exec_done),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Next PC straight from the architectural rules, using integer arithmetic.
  function automatic int model_next(input int pc, input logic [15:0] ins,
                                    input logic j, input logic b, input logic z);
    int p2;
    int imm;
    p2 = (pc + 2) % 65536;
    if (j) return (p2 / 16384) * 16384 + int'(ins[12:0]) * 2;
    if (b && z) begin
      imm = int'(ins[6:0]);
      if (imm > 63) imm = imm - 128;
      return (p2 + imm * 2 + 65536) % 65536;
    end
    return p2;
  endfunction

  task automatic fetch(input int ack_dly, input logic [15:0] rd, input logic j,
                       input logic b, input logic z, input int ex_dly);
    for (int i = 0; i < ack_dly; i++) begin
      check("req_wait", 16'(imem_req), 16'd1);
      check("addr_wait", imem_addr, 16'(exp_pc));
      check("valid_wait", 16'(instr_valid), 16'd0);
      exec_done  = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      tick();
      exec_done = 1'b0;
    end
    check("req", 16'(imem_req), 16'd1);
    check("addr", imem_addr, 16'(exp_pc));
    imem_ack   = 1'b1;
    imem_rdata = rd;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    check("valid", 16'(instr_valid), 16'd1);
    check("instr", instr, rd);
    check("opcode", 16'(opcode), 16'(rd[15:13]));
    check("pc_plus2", pc_plus2, 16'((exp_pc + 2) % 65536));
    check("req_issue", 16'(imem_req), 16'd0);
    jump = j; branch = b; zero = z;
    for (int i = 0; i < ex_dly; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      imem_ack = 1'b0;
      check("hold_valid", 16'(instr_valid), 16'd1);
      check("hold_instr", instr, rd);
      check("hold_pc_plus2", pc_plus2, 16'((exp_pc + 2) % 65536));
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    exp_pc = model_next(exp_pc, rd, j, b, z);
    exp_count = (exp_count + 1) % 65536;
    check("count", instr_count, 16'(exp_count));
    check("req_next", 16'(imem_req), 16'd1);
    check("valid_next", 16'(instr_valid), 16'd0);
    check("next_addr", imem_addr, 16'(exp_pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] add_w, beq_m2, rd;
    logic rj, rb, rz;
    add_w  = {OP_ADD, 13'h0000};
    beq_m2 = {OP_BEQ, 6'h00, 7'h7E};

    // Reset state
    tick(); tick(); tick();
    check("rst_req", 16'(imem_req), 16'd0);
    check("rst_valid", 16'(instr_valid), 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_count", instr_count, 16'h0000);
    check("rst_addr", imem_addr, 16'h0000);
    reset = 1'b0;
    check("idle_req", 16'(imem_req), 16'd0);
    tick();
    check("idle_to_req", 16'(imem_req), 16'd1);

    // Reset in ISSUE with exec_done discards the retirement
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    check("pre_rst_valid", 16'(instr_valid), 16'd1);
    exec_done = 1'b1; reset = 1'b1;
    tick();
    exec_done = 1'b0;
    check("rst_issue_valid", 16'(instr_valid), 16'd0);
    check("rst_issue_count", instr_count, 16'h0000);
    check("rst_issue_addr", imem_addr, 16'h0000);
    reset = 1'b0;
    tick();
    // Reset in REQ with a same-cycle ack discards the data
    imem_ack = 1'b1; imem_rdata = 16'hBEEF; reset = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("rst_req_instr", instr, 16'h0000);
    check("rst_req_valid", 16'(instr_valid), 16'd0);
    reset = 1'b0;
    tick();

    // Zero-wait sequential fetches
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    check("seq_addr2", imem_addr, 16'h0002);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    check("seq_addr4", imem_addr, 16'h0004);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    check("seq_count3", instr_count, 16'd3);

    // Ack held off five cycles
    fetch(5, add_w, 1'b0, 1'b0, 1'b0, 2);

    // Branch taken/not taken at 0x0010
    fetch(0, {OP_J, 13'h0008}, 1'b1, 1'b0, 1'b0, 0);
    check("at_0010", imem_addr, 16'h0010);
    fetch(0, beq_m2, 1'b0, 1'b1, 1'b1, 1);
    check("beq_taken", imem_addr, 16'h000E);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    fetch(0, beq_m2, 1'b0, 1'b1, 1'b0, 0);
    check("beq_not_taken", imem_addr, 16'h0012);

    // Jump at 0x4000
    fetch(0, {OP_J, 13'h1FFF}, 1'b1, 1'b0, 1'b0, 0);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    check("at_4000", imem_addr, 16'h4000);
    fetch(0, {OP_J, 13'h0123}, 1'b1, 1'b0, 1'b0, 0);
    check("jump_4246", imem_addr, 16'h4246);

    // Walk up to 0xFFFE and wrap
    fetch(0, {OP_J, 13'h1FFF}, 1'b1, 1'b0, 1'b0, 0);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    fetch(0, {OP_J, 13'h1FFF}, 1'b1, 1'b0, 1'b0, 0);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);
    fetch(0, {OP_J, 13'h1FFF}, 1'b1, 1'b0, 1'b0, 0);
    check("at_fffe", imem_addr, 16'hFFFE);
    fetch(3, add_w, 1'b0, 1'b0, 1'b0, 0);
    check("wrap_0000", imem_addr, 16'h0000);
    fetch(0, beq_m2, 1'b0, 1'b1, 1'b1, 0);
    check("back_wrap", imem_addr, 16'hFFFE);
    fetch(0, add_w, 1'b0, 1'b0, 1'b0, 0);

    // Randomized fetch traffic
    for (int n = 0; n < 40; n++) begin
      rd = 16'($urandom);
      rj = ($urandom_range(0, 3) == 0);
      rb = 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1));
      fetch(int'($urandom_range(0, 3)), rd, rj, rb, rz, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
